// File: rtl/timer_pkg.sv
// Shared constants for the timer scheduler: config field codes,
// CTRL bit positions and read latency.
package timer_pkg;

    typedef enum logic [1:0] {
        FLD_CTRL = 2'd0,
        FLD_CMP  = 2'd1,
        FLD_CNT  = 2'd2,
        FLD_RSVD = 2'd3
    } fld_e;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int RD_LAT       = 1;

endpackage

// File: rtl/timer_sched_if.sv
// Config/read bus and interrupt outputs of the timer scheduler.
// master = CPU side, slave = timer block.
interface timer_sched_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32
);
    localparam int CH_W = $clog2(NUM_CH);

    logic              cfg_we;
    logic [CH_W-1:0]   cfg_sel;
    logic [1:0]        cfg_field;
    logic [WIDTH-1:0]  cfg_wdata;
    logic              cfg_re;
    logic [WIDTH-1:0]  cfg_rdata;
    logic              cfg_rvalid;
    logic              irq_ack;
    logic [CH_W-1:0]   ack_id;
    logic              irq;
    logic [CH_W-1:0]   irq_id;
    logic [NUM_CH-1:0] pend;
    logic [CH_W-1:0]   slot;

    modport master (
        output cfg_we, cfg_sel, cfg_field, cfg_wdata, cfg_re, irq_ack, ack_id,
        input  cfg_rdata, cfg_rvalid, irq, irq_id, pend, slot
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_field, cfg_wdata, cfg_re, irq_ack, ack_id,
        output cfg_rdata, cfg_rvalid, irq, irq_id, pend, slot
    );
endinterface

// File: rtl/timer_prio_enc.sv
// Lowest-index-wins priority encoder over the pending flags.
module timer_prio_enc #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         pend,
    output logic                      irq,
    output logic [$clog2(NUM_CH)-1:0] irq_id
);
    localparam int CH_W = $clog2(NUM_CH);

    always_comb begin
        irq    = |pend;
        irq_id = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (pend[i]) irq_id = CH_W'(i);
    end
endmodule

// File: rtl/timer_sched.sv
// Multi-channel timer: one shared increment/compare datapath visits a
// channel per cycle in round-robin order; hits latch into pending flags.
module timer_sched
    import timer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32
) (
    input logic       clk,
    input logic       rst_n,
    timer_sched_if.slave bus
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]            en, oneshot, pend, set_mask, ack_mask;
    logic [NUM_CH-1:0][WIDTH-1:0] cmp, cnt;
    logic [CH_W-1:0]              slot;
    logic [WIDTH-1:0]             rdata, rd_mux;
    logic [RD_LAT-1:0]            vld_pipe;
    logic                         hit;

    // Compare one bit wider than the count so cnt+1 never wraps.
    always_comb begin
        hit = ({1'b0, cnt[slot]} + (WIDTH+1)'(1)) >= {1'b0, cmp[slot]};
        set_mask       = '0;
        set_mask[slot] = en[slot] & hit;
        ack_mask               = '0;
        ack_mask[bus.ack_id]   = bus.irq_ack;
    end

    always_comb begin
        rd_mux = '0;
        case (fld_e'(bus.cfg_field))
            FLD_CTRL: begin
                rd_mux[CTRL_EN]      = en[bus.cfg_sel];
                rd_mux[CTRL_ONESHOT] = oneshot[bus.cfg_sel];
            end
            FLD_CMP: rd_mux = cmp[bus.cfg_sel];
            FLD_CNT: rd_mux = cnt[bus.cfg_sel];
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en       <= '0;
            oneshot  <= '0;
            cmp      <= '0;
            cnt      <= '0;
            pend     <= '0;
            slot     <= '0;
            rdata    <= '0;
            vld_pipe <= '0;
        end else begin
            slot <= slot + CH_W'(1);
            // set is OR-ed after the ack clear so a coincident hit survives
            pend <= (pend & ~ack_mask) | set_mask;

            if (en[slot]) begin
                if (hit) begin
                    if (oneshot[slot]) en[slot]  <= 1'b0;
                    else               cnt[slot] <= '0;
                end else begin
                    cnt[slot] <= cnt[slot] + WIDTH'(1);
                end
            end

            // Placed after the service update so a write to the serviced channel wins.
            if (bus.cfg_we) begin
                case (fld_e'(bus.cfg_field))
                    FLD_CTRL: begin
                        en[bus.cfg_sel]      <= bus.cfg_wdata[CTRL_EN];
                        oneshot[bus.cfg_sel] <= bus.cfg_wdata[CTRL_ONESHOT];
                    end
                    FLD_CMP: cmp[bus.cfg_sel] <= bus.cfg_wdata;
                    FLD_CNT: cnt[bus.cfg_sel] <= bus.cfg_wdata;
                    default: ;
                endcase
            end

            if (bus.cfg_re) rdata <= rd_mux;
            vld_pipe[0] <= bus.cfg_re;
            for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign bus.cfg_rdata  = rdata;
    assign bus.cfg_rvalid = vld_pipe[RD_LAT-1];
    assign bus.pend       = pend;
    assign bus.slot       = slot;

    timer_prio_enc #(.NUM_CH(NUM_CH)) u_prio (
        .pend   (pend),
        .irq    (bus.irq),
        .irq_id (bus.irq_id)
    );
endmodule

// File: doc/timer_sched.md
Name: timer_sched

Overview:
Multi-channel timer controller. It time-shares one incrementer/comparator datapath across NUM_CH timer channels in round-robin slots. It holds each channel's configuration and count, and latches per-channel interrupts into pending flags. A single prioritised interrupt line, with the channel id, goes to the CPU-side interrupt logic.

Parameters:
NUM_CH, 4, number of timer channels (power of 2, ≥2)
WIDTH, 32, count/compare width in bits
CH_W, $clog2(NUM_CH), channel index width (derived, not overridable)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  config write strobe, one write per cycle, always accepted
cfg_sel  in  CH_W  target channel for write/read
cfg_field  in  2  0=CTRL, 1=CMP, 2=CNT, 3=reserved (writes ignored, reads 0)
cfg_wdata  in  WIDTH  write data; CTRL uses bit0=en, bit1=oneshot
cfg_re  in  1  read strobe
cfg_rdata  out  WIDTH  read data, valid the cycle after cfg_re
cfg_rvalid  out  1  one-cycle pulse qualifying cfg_rdata
irq_ack  in  1  clear pending flag of channel ack_id
ack_id  in  CH_W  channel to acknowledge
irq  out  1  level, high while any pending flag is set
irq_id  out  CH_W  lowest-index pending channel; 0 when none
pend  out  NUM_CH  raw pending flags
slot  out  CH_W  channel serviced this cycle

Behaviour:
- Reset (rst_n=0, asynchronous): all en, oneshot, cmp and cnt are 0; pend=0; slot=0; cfg_rdata=0; cfg_rvalid=0; irq=0; irq_id=0.
- Slot pointer: slot increments every cycle and wraps NUM_CH-1→0. Channel c is serviced in exactly one cycle per NUM_CH cycles, so its tick period is NUM_CH clk.
- Service of channel c=slot, only if en[c]=1:
  - Compare uses (WIDTH+1)-bit arithmetic: hit = ({1'b0,cnt}+1 ≥ {1'b0,cmp}). No overflow.
  - On hit: pend[c] is set.
    - Periodic (oneshot=0): cnt←0.
    - Oneshot (oneshot=1): cnt holds and en[c] is cleared.
  - On no hit: cnt←cnt+1.
  - cmp=0 gives a hit on every service.
- When en[c]=0: channel c is frozen (cnt unchanged, no set).
- Config write takes effect at the next clock edge. If it targets the channel being serviced in that cycle, the write wins over the service update for the written field. A service-side pend set still occurs.
- CTRL write: updates en and oneshot only; cnt is untouched. Re-arming a finished oneshot requires a CNT write to restart counting from 0.
- Reads: cfg_re captures the addressed field into cfg_rdata; cfg_rvalid pulses one cycle later.
  - CTRL reads back {…0, oneshot, en}.
  - CNT returns the registered value before any same-cycle update.
- Pending flags:
  - irq_ack clears pend[ack_id] at the next edge.
  - A same-cycle set and ack on one channel: set wins (pend stays 1).
  - Ack of a non-pending channel has no effect.
- irq and irq_id are combinational from the pend register: one cycle after a hit, with no extra latency.
- Reset mid-operation immediately returns every register to its reset value. No residual pend.

Decomposition:
- Package timer_pkg holds: field codes FLD_CTRL/FLD_CMP/FLD_CNT, CTRL bit positions CTRL_EN=0 and CTRL_ONESHOT=1, and the read-latency constant 1.
- One sub-module, timer_prio_enc: parameterised lowest-index priority encoder producing irq_id and irq from pend.
- Channel state lives in register arrays inside timer_sched. No per-channel instances, so the datapath stays genuinely shared.

Test Plan:
1. Reset: hold rst_n=0 mid-run, then release. All outputs and read-back fields are 0; slot counts 0,1,2,3,0.
2. ch0 periodic: write cmp=3, then ctrl=0b01. pend[0] first sets after the 3rd service of ch0, re-sets every 3 services (12 clk). cnt reads cycle 0,1,2,0.
3. ch2 oneshot: write cmp=2, then ctrl=0b11. pend[2] sets once; CTRL reads 0b10 (en auto-cleared); cnt reads 1 and holds. After ack, no further irq for 40 clk.
4. Priority/ack: ch1 and ch3 both pending. irq=1 and irq_id=1. ack_id=1 gives irq_id=3 next cycle; ack_id=3 gives irq=0.
5. Collisions:
   - CNT write of 5 to ch0 in its own slot: the read shows 5 (write beats increment).
   - ack on the same cycle as a hit: pend stays 1.
6. Boundary: cmp=0 with en=1 sets pend every service. cmp=32'hFFFFFFFF with cnt preloaded to 32'hFFFFFFFE hits on the next service without wrap.
